// File: rtl/i2c_target_regfile.sv
// i2c_target_regfile: I2C target serving a byte-wide register file with auto-incrementing pointer.
// Define I2C_TARGET_GLITCH_FILTER_EN to add a 3-sample majority filter after each synchronizer.
module i2c_target_regfile #(
  parameter logic [6:0] I2C_ADDR = 7'h50,
  parameter int N_REG = 16,
  parameter int PW = $clog2(N_REG)
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          SCL_i,
  output logic          SCL_o,
  output logic          SCL_t,
  input  logic          SDA_i,
  output logic          SDA_o,
  output logic          SDA_t,
  output logic [PW-1:0] reg_addr,
  output logic          reg_wr_en,
  output logic [7:0]    reg_wr_data,
  input  logic [7:0]    reg_rd_data,
  output logic          busy
);
  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE
  } state_t;
  state_t state;
  logic [1:0] scl_s, sda_s;
  logic scl_c, sda_c, scl_p, sda_p;
  logic [6:0] shreg;
  logic [2:0] bit_cnt;
  logic rw;
  assign SCL_o = 1'b0;
  assign SCL_t = 1'b1;
  assign SDA_o = 1'b0;
  always_ff @(posedge clk)
    if (!resetn) begin
      scl_s <= '1;
      sda_s <= '1;
    end else begin
      scl_s <= {scl_s[0], SCL_i};
      sda_s <= {sda_s[0], SDA_i};
    end
`ifdef I2C_TARGET_GLITCH_FILTER_EN
  logic [2:0] scl_h, sda_h;
  always_ff @(posedge clk)
    if (!resetn) begin
      scl_h <= '1;
      sda_h <= '1;
    end else begin
      scl_h <= {scl_h[1:0], scl_s[1]};
      sda_h <= {sda_h[1:0], sda_s[1]};
    end
  assign scl_c = (scl_h[0] & scl_h[1]) | (scl_h[0] & scl_h[2]) | (scl_h[1] & scl_h[2]);
  assign sda_c = (sda_h[0] & sda_h[1]) | (sda_h[0] & sda_h[2]) | (sda_h[1] & sda_h[2]);
`else
  assign scl_c = scl_s[1];
  assign sda_c = sda_s[1];
`endif
  always_ff @(posedge clk)
    if (!resetn) begin
      scl_p <= 1'b1;
      sda_p <= 1'b1;
    end else begin
      scl_p <= scl_c;
      sda_p <= sda_c;
    end
  logic start, stop, rise, fall, last, ptr_ok;
  logic [7:0] b;
  logic [PW-1:0] nxt_addr;
  assign start    = scl_p & scl_c & sda_p & ~sda_c;
  assign stop     = scl_p & scl_c & ~sda_p & sda_c;
  assign rise     = scl_c & ~scl_p;
  assign fall     = ~scl_c & scl_p;
  assign b        = {shreg, sda_c};
  assign last     = bit_cnt == 3'd7;
  assign ptr_ok   = {1'b0, b} < 9'(N_REG);
  assign nxt_addr = (reg_addr == PW'(N_REG - 1)) ? '0 : reg_addr + 1'b1;
  // ACK states use SDA_t itself as the phase flag: first falling edge drives low, second releases.
  always_ff @(posedge clk)
    if (!resetn) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      shreg       <= '0;
      rw          <= 1'b0;
      SDA_t       <= 1'b1;
      busy        <= 1'b0;
      reg_addr    <= '0;
      reg_wr_en   <= 1'b0;
      reg_wr_data <= '0;
    end else begin
      reg_wr_en <= 1'b0;
      if (start) begin
        state   <= ADDR;
        bit_cnt <= '0;
        SDA_t   <= 1'b1;
      end else if (stop) begin
        state <= IDLE;
        busy  <= 1'b0;
        SDA_t <= 1'b1;
      end else
        case (state)
          ADDR: if (rise) begin
            shreg   <= b[6:0];
            bit_cnt <= bit_cnt + 1'b1;
            if (last) begin
              state <= (b[7:1] == I2C_ADDR) ? ADDR_ACK : IGNORE;
              busy  <= busy | (b[7:1] == I2C_ADDR);
              rw    <= b[0];
            end
          end
          PTR: if (rise) begin
            shreg   <= b[6:0];
            bit_cnt <= bit_cnt + 1'b1;
            if (last) begin
              state <= ptr_ok ? PTR_ACK : IGNORE;
              if (ptr_ok) reg_addr <= b[PW-1:0];
            end
          end
          WDATA: if (rise) begin
            shreg   <= b[6:0];
            bit_cnt <= bit_cnt + 1'b1;
            if (last) begin
              reg_wr_data <= b;
              reg_wr_en   <= 1'b1;
              state       <= WDATA_ACK;
            end
          end
          ADDR_ACK: if (fall) begin
            if (SDA_t) SDA_t <= 1'b0;
            else if (rw) begin
              shreg <= reg_rd_data[6:0];
              SDA_t <= reg_rd_data[7];
              state <= RDATA;
            end else begin
              SDA_t <= 1'b1;
              state <= PTR;
            end
          end
          PTR_ACK: if (fall) begin
            SDA_t <= ~SDA_t;
            if (!SDA_t) state <= WDATA;
          end
          WDATA_ACK: if (fall) begin
            SDA_t <= ~SDA_t;
            if (!SDA_t) begin
              state    <= WDATA;
              reg_addr <= nxt_addr;
            end
          end
          RDATA: if (rise) begin
            bit_cnt <= bit_cnt + 1'b1;
            if (last) state <= RDATA_ACK;
          end else if (fall) begin
            SDA_t <= shreg[6];
            shreg <= {shreg[5:0], 1'b0};
          end
          // bit_cnt[0] marks that the initiator ACKed and the next byte loads on the falling edge.
          RDATA_ACK: if (rise) begin
            if (sda_c) state <= IGNORE;
            else begin
              bit_cnt  <= 3'd1;
              reg_addr <= nxt_addr;
            end
          end else if (fall) begin
            if (bit_cnt[0]) begin
              shreg   <= reg_rd_data[6:0];
              SDA_t   <= reg_rd_data[7];
              bit_cnt <= '0;
              state   <= RDATA;
            end else SDA_t <= 1'b1;
          end
          default: ;
        endcase
    end
endmodule

// File: tb/tb_i2c_target_regfile.sv
// tb_i2c_target_regfile: bit-banged I2C initiator with write/read scoreboards against a register-file model.
module tb_i2c_target_regfile;
  localparam int Q = 8;
`ifdef I2C_TARGET_GLITCH_FILTER_EN
  localparam bit FILT = 1'b1;
`else
  localparam bit FILT = 1'b0;
`endif
  logic clk = 1'b0, resetn = 1'b0, scl_m = 1'b1, sda_m = 1'b1;
  logic SCL_o, SCL_t, SDA_o, SDA_t, reg_wr_en, busy;
  logic [3:0] reg_addr;
  logic [7:0] reg_wr_data, reg_rd_data;
  logic [7:0] mem [16] = '{default: 8'h00};
  logic [11:0] wr_q [$];
  logic [7:0] rd_q [$];
  int n_cmp = 0, n_err = 0, sda_low_cnt = 0;
  wire SCL_i = scl_m & (SCL_t | SCL_o);
  wire SDA_i = sda_m & (SDA_t | SDA_o);
  assign reg_rd_data = mem[reg_addr];
  always #5 clk = ~clk;
  i2c_target_regfile dut (
    .clk(clk), .resetn(resetn), .SCL_i(SCL_i), .SCL_o(SCL_o), .SCL_t(SCL_t),
    .SDA_i(SDA_i), .SDA_o(SDA_o), .SDA_t(SDA_t), .reg_addr(reg_addr),
    .reg_wr_en(reg_wr_en), .reg_wr_data(reg_wr_data), .reg_rd_data(reg_rd_data), .busy(busy)
  );
  // every bench wait goes through tick, which also pops the write scoreboard
  task automatic tick(input int n = 1);
    logic [11:0] e;
    repeat (n) begin
      @(posedge clk);
      #1;
      if (!SDA_t) sda_low_cnt++;
      if (reg_wr_en) begin
        mem[reg_addr] = reg_wr_data;
        n_cmp++;
        if (wr_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_write: got addr %0d data %02h, required no write", reg_addr, reg_wr_data);
        end else begin
          e = wr_q.pop_front();
          if ({reg_addr, reg_wr_data} !== e) begin
            n_err++;
            $display("FAIL write: got addr %0d data %02h, required addr %0d data %02h", reg_addr, reg_wr_data, e[11:8], e[7:0]);
          end
        end
      end
    end
  endtask
  task automatic i2c_start();
    sda_m = 1'b1; tick(Q);
    scl_m = 1'b1; tick(Q);
    sda_m = 1'b0; tick(Q);
    scl_m = 1'b0; tick(Q);
  endtask
  task automatic i2c_stop();
    sda_m = 1'b0; tick(Q);
    scl_m = 1'b1; tick(Q);
    sda_m = 1'b1; tick(Q);
  endtask
  task automatic write_bit(input logic v, input bit glitch = 1'b0);
    sda_m = v; tick(Q);
    scl_m = 1'b1; tick(Q);
    if (glitch) begin
      sda_m = 1'b0; tick(1);
      sda_m = 1'b1; tick(Q - 1);
    end else tick(Q);
    scl_m = 1'b0; tick(Q);
  endtask
  task automatic read_bit(output logic v);
    sda_m = 1'b1; tick(Q);
    scl_m = 1'b1; tick(Q);
    v = SDA_i; tick(Q);
    scl_m = 1'b0; tick(Q);
  endtask
  task automatic write_byte(input logic [7:0] d, output logic ack, input int glitch_bit = -1);
    logic a;
    for (int i = 7; i >= 0; i--) write_bit(d[i], i == glitch_bit);
    read_bit(a);
    ack = ~a;
  endtask
  task automatic read_byte(output logic [7:0] d, input logic ack);
    for (int i = 7; i >= 0; i--) read_bit(d[i]);
    write_bit(~ack);
  endtask
  task automatic test_reset();
    resetn = 1'b0; tick(3);
    n_cmp++; if (SDA_t !== 1'b1) begin n_err++; $display("FAIL rst_sda_t: got %b required 1", SDA_t); end
    n_cmp++; if (SCL_t !== 1'b1) begin n_err++; $display("FAIL rst_scl_t: got %b required 1", SCL_t); end
    n_cmp++; if ({SDA_o, SCL_o} !== 2'b00) begin n_err++; $display("FAIL rst_o: got %b required 00", {SDA_o, SCL_o}); end
    n_cmp++; if (reg_wr_en !== 1'b0) begin n_err++; $display("FAIL rst_wr_en: got %b required 0", reg_wr_en); end
    n_cmp++; if (reg_wr_data !== 8'h00) begin n_err++; $display("FAIL rst_wr_data: got %02h required 00", reg_wr_data); end
    n_cmp++; if (reg_addr !== 4'd0) begin n_err++; $display("FAIL rst_addr: got %0d required 0", reg_addr); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b required 0", busy); end
    resetn = 1'b1; tick(4);
  endtask
  task automatic test_write();
    logic ack;
    i2c_start();
    write_byte(8'hA0, ack);
    n_cmp++; if (ack !== 1'b1) begin n_err++; $display("FAIL wr_addr_ack: got %b required 1", ack); end
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL wr_busy: got %b required 1", busy); end
    write_byte(8'h03, ack);
    n_cmp++; if (ack !== 1'b1) begin n_err++; $display("FAIL wr_ptr_ack: got %b required 1", ack); end
    wr_q.push_back({4'd3, 8'h5A});
    write_byte(8'h5A, ack);
    n_cmp++; if (ack !== 1'b1) begin n_err++; $display("FAIL wr_d0_ack: got %b required 1", ack); end
    wr_q.push_back({4'd4, 8'hC3});
    write_byte(8'hC3, ack);
    n_cmp++; if (ack !== 1'b1) begin n_err++; $display("FAIL wr_d1_ack: got %b required 1", ack); end
    i2c_stop();
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL wr_busy_stop: got %b required 0", busy); end
  endtask
  task automatic test_read();
    logic ack;
    logic [7:0] d, e;
    i2c_start();
    write_byte(8'hA0, ack);
    write_byte(8'h07, ack);
    wr_q.push_back({4'd7, 8'h81});
    write_byte(8'h81, ack);
    wr_q.push_back({4'd8, 8'h7E});
    write_byte(8'h7E, ack);
    i2c_start();
    write_byte(8'hA0, ack);
    write_byte(8'h07, ack);
    n_cmp++; if (ack !== 1'b1) begin n_err++; $display("FAIL rd_ptr_ack: got %b required 1", ack); end
    i2c_start();
    write_byte(8'hA1, ack);
    n_cmp++; if (ack !== 1'b1) begin n_err++; $display("FAIL rd_addr_ack: got %b required 1", ack); end
    rd_q.push_back(8'h81);
    rd_q.push_back(8'h7E);
    read_byte(d, 1'b1);
    e = rd_q.pop_front();
    n_cmp++; if (d !== e) begin n_err++; $display("FAIL rd_byte0: got %02h required %02h", d, e); end
    read_byte(d, 1'b0);
    e = rd_q.pop_front();
    n_cmp++; if (d !== e) begin n_err++; $display("FAIL rd_byte1: got %02h required %02h", d, e); end
    i2c_stop();
    n_cmp++; if (reg_addr !== 4'd8) begin n_err++; $display("FAIL rd_addr_end: got %0d required 8", reg_addr); end
  endtask
  task automatic test_wrong_addr();
    logic ack;
    int snap;
    snap = sda_low_cnt;
    i2c_start();
    write_byte(8'hB0, ack);
    n_cmp++; if (ack !== 1'b0) begin n_err++; $display("FAIL wa_addr_ack: got %b required 0", ack); end
    write_byte(8'h01, ack);
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL wa_busy: got %b required 0", busy); end
    i2c_stop();
    n_cmp++; if (sda_low_cnt !== snap) begin n_err++; $display("FAIL wa_sda_low: got %0d low cycles required 0", sda_low_cnt - snap); end
  endtask
  task automatic test_wrap();
    logic ack;
    int snap;
    i2c_start();
    write_byte(8'hA0, ack);
    write_byte(8'h0F, ack);
    wr_q.push_back({4'd15, 8'h11});
    write_byte(8'h11, ack);
    wr_q.push_back({4'd0, 8'h22});
    write_byte(8'h22, ack);
    n_cmp++; if (ack !== 1'b1) begin n_err++; $display("FAIL wrap_ack: got %b required 1", ack); end
    i2c_stop();
    i2c_start();
    write_byte(8'hA0, ack);
    snap = sda_low_cnt;
    write_byte(8'h10, ack);
    n_cmp++; if (ack !== 1'b0) begin n_err++; $display("FAIL bad_ptr_ack: got %b required 0", ack); end
    write_byte(8'h99, ack);
    i2c_stop();
    n_cmp++; if (sda_low_cnt !== snap) begin n_err++; $display("FAIL bad_ptr_sda: got %0d low cycles required 0", sda_low_cnt - snap); end
    n_cmp++; if (reg_addr !== 4'd1) begin n_err++; $display("FAIL bad_ptr_addr: got %0d required 1", reg_addr); end
  endtask
  task automatic test_stop_mid();
    logic ack;
    i2c_start();
    write_byte(8'hA0, ack);
    write_byte(8'h02, ack);
    for (int i = 0; i < 4; i++) write_bit(1'b1);
    i2c_stop();
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL mid_busy: got %b required 0", busy); end
    n_cmp++; if (SDA_t !== 1'b1) begin n_err++; $display("FAIL mid_sda_t: got %b required 1", SDA_t); end
    i2c_start();
    write_byte(8'hA0, ack);
    write_byte(8'h02, ack);
    wr_q.push_back({4'd2, 8'h44});
    write_byte(8'h44, ack);
    n_cmp++; if (ack !== 1'b1) begin n_err++; $display("FAIL mid_recover_ack: got %b required 1", ack); end
    i2c_stop();
  endtask
  task automatic test_reset_mid();
    logic ack;
    i2c_start();
    for (int i = 7; i >= 0; i--) write_bit(i == 7 || i == 5);
    n_cmp++; if (SDA_t !== 1'b0) begin n_err++; $display("FAIL rm_ack_drive: got %b required 0", SDA_t); end
    resetn = 1'b0; tick(1);
    n_cmp++; if (SDA_t !== 1'b1) begin n_err++; $display("FAIL rm_release: got %b required 1", SDA_t); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rm_busy: got %b required 0", busy); end
    resetn = 1'b1; tick(2);
    i2c_stop();
    i2c_start();
    write_byte(8'hA0, ack);
    n_cmp++; if (ack !== 1'b1) begin n_err++; $display("FAIL rm_recover_ack: got %b required 1", ack); end
    write_byte(8'h0A, ack);
    wr_q.push_back({4'd10, 8'h3C});
    write_byte(8'h3C, ack);
    i2c_stop();
  endtask
  task automatic test_glitch();
    logic ack;
    i2c_start();
    write_byte(8'hA0, ack);
    write_byte(8'h05, ack);
    if (FILT) wr_q.push_back({4'd5, 8'h33});
    write_byte(8'h33, ack, 4);
    n_cmp++; if (ack !== FILT) begin n_err++; $display("FAIL glitch_ack: got %b required %b", ack, FILT); end
    i2c_stop();
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL glitch_busy: got %b required 0", busy); end
  endtask
  initial begin
    test_reset();
    test_write();
    test_read();
    test_wrong_addr();
    test_wrap();
    test_stop_mid();
    test_reset_mid();
    test_glitch();
    tick(4);
    n_cmp++;
    if (wr_q.size() != 0) begin
      n_err++;
      $display("FAIL pending_writes: got %0d outstanding required 0", wr_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
